// File: rtl/dsp_nco_mc_if.sv
// dsp_nco_mc_if: control and sample-stream bundle for the multi-channel NCO.
//   master : drives en, sync, cfg_we/cfg_ch/cfg_sel/cfg_data/cfg_commit;
//            observes cfg_pending and the out_valid/out_ch/sin_o/cos_o stream.
//   slave  : the NCO itself.
interface dsp_nco_mc_if #(
  parameter int NUM_CH     = 4,
  parameter int PHI_WIDTH  = 16,
  parameter int DATA_WIDTH = 12
);
  localparam int CW = $clog2(NUM_CH);

  logic                         en;
  logic                         sync;
  logic                         cfg_we;
  logic [CW-1:0]                cfg_ch;
  logic                         cfg_sel;
  logic [PHI_WIDTH-1:0]         cfg_data;
  logic                         cfg_commit;
  logic                         cfg_pending;
  logic                         out_valid;
  logic [CW-1:0]                out_ch;
  logic signed [DATA_WIDTH-1:0] sin_o;
  logic signed [DATA_WIDTH-1:0] cos_o;

  modport master (
    output en, sync, cfg_we, cfg_ch, cfg_sel, cfg_data, cfg_commit,
    input  cfg_pending, out_valid, out_ch, sin_o, cos_o
  );
  modport slave (
    input  en, sync, cfg_we, cfg_ch, cfg_sel, cfg_data, cfg_commit,
    output cfg_pending, out_valid, out_ch, sin_o, cos_o
  );
endinterface

// File: rtl/dsp_nco_mc.sv
// dsp_nco_mc: time-multiplexed NCO. NUM_CH phase accumulators share one
// quarter-wave sine table; one channel (sin+cos) per enabled clock, round-robin.
// Shadow inc/off registers are copied to the active set at a frame start after
// cfg_commit; sync zeroes all accumulators at the next frame start.
// Ports: clk, rst (async, active-high), bus (dsp_nco_mc_if.slave):
//   en, sync, cfg_we/cfg_ch/cfg_sel/cfg_data/cfg_commit in;
//   cfg_pending, out_valid, out_ch, sin_o, cos_o out.
// Pipeline: stage0 phase -> stage1 table reads -> stage2 signed outputs.
module dsp_nco_mc #(
  parameter int    NUM_CH     = 4,
  parameter int    PHI_WIDTH  = 16,
  parameter int    ADDR_WIDTH = 12,
  parameter int    DATA_WIDTH = 12,
  parameter int    USE_DITHER = 0,
  parameter string FILE_QSIN  = "dsp_nco_rom_qsin.txt"
) (
  input  logic clk,
  input  logic rst,
  dsp_nco_mc_if.slave bus
);
  localparam int CW     = $clog2(NUM_CH);
  localparam int IW     = ADDR_WIDTH - 2;          // quarter-wave index width
  localparam int QN     = 2**IW;                   // quarter-wave entries
  localparam int MW     = DATA_WIDTH - 1;          // table magnitude width
  localparam int TW     = PHI_WIDTH - ADDR_WIDTH;  // bits below the lookup
  localparam int STAGES = 2;
  localparam int INNER  = (QN < 32) ? QN : 32;

  // The quarter-wave table is built at elaboration from the same formula that
  // produces the FILE_QSIN hex image, so no file read is needed; the name is
  // still accepted so existing instantiations bind unchanged.
  if (FILE_QSIN == "") begin : g_qsin_chk
    $error("FILE_QSIN must name the quarter-sine table");
  end

  typedef logic [QN-1:0][MW-1:0] rom_t;

  // Split loop keeps each elaboration loop short.
  function automatic rom_t gen_rom();
    rom_t r;
    real  amp, ang;
    int   k;
    r   = '0;
    amp = real'(2**MW - 1);
    for (int hi = 0; hi < QN / INNER; hi++) begin
      for (int lo = 0; lo < INNER; lo++) begin
        k    = hi * INNER + lo;
        ang  = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(4 * QN);
        r[k] = MW'($rtoi(amp * $sin(ang) + 0.5));
      end
    end
    return r;
  endfunction

  localparam rom_t ROM = gen_rom();

  logic [CW-1:0]                        slot_q, slot_d;
  logic [NUM_CH-1:0][PHI_WIDTH-1:0]     acc_q, acc_d, inc_q, inc_d, off_q, off_d;
  logic [NUM_CH-1:0][PHI_WIDTH-1:0]     sh_inc_q, sh_inc_d, sh_off_q, sh_off_d;
  logic                                 pend_q, pend_d, sync_q, sync_d;
  logic [STAGES:0]                      vld_pipe_q, vld_pipe_d;
  logic [STAGES:0][CW-1:0]              ch_q, ch_d;
  logic [ADDR_WIDTH-1:0]                a_q, a_d;
  logic [MW-1:0]                        sin_m_q, sin_m_d, cos_m_q, cos_m_d;
  logic                                 sin_neg_q, sin_neg_d, cos_neg_q, cos_neg_d;
  logic signed [DATA_WIDTH-1:0]         sin_q, sin_d, cos_q, cos_d;

  logic                 frame_start, apply, zero;
  logic [PHI_WIDTH-1:0] cur_acc, cur_inc, cur_off, phase, dith;
  logic [IW-1:0]        idx, sin_addr, cos_addr;
  logic [DATA_WIDTH-1:0] sin_ext, cos_ext;

  // Dither source: x^16+x^14+x^13+x^11+1, stepping on every enabled cycle.
  if (USE_DITHER != 0 && TW > 0) begin : g_dith
    localparam logic [PHI_WIDTH-1:0] DMASK = (PHI_WIDTH'(1) << TW) - 1'b1;
    logic [15:0] lfsr_q, lfsr_d;
    always_comb begin
      lfsr_d = lfsr_q;
      if (bus.en) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) lfsr_q <= '1;
      else     lfsr_q <= lfsr_d;
    assign dith = PHI_WIDTH'(lfsr_q) & DMASK;
  end else begin : g_nodith
    assign dith = '0;
  end

  // Stage 0: phase for the current slot, with commit/sync taking effect on
  // the frame-start slot itself.
  always_comb begin
    frame_start = bus.en && (slot_q == '0);
    apply       = frame_start && pend_q;
    zero        = frame_start && sync_q;
    cur_inc     = apply ? sh_inc_q[slot_q] : inc_q[slot_q];
    cur_off     = apply ? sh_off_q[slot_q] : off_q[slot_q];
    cur_acc     = zero ? '0 : acc_q[slot_q];
    phase       = cur_acc + cur_off + dith;

    slot_d   = slot_q;
    acc_d    = acc_q;
    inc_d    = inc_q;
    off_d    = off_q;
    sh_inc_d = sh_inc_q;
    sh_off_d = sh_off_q;
    a_d      = a_q;
    // A request landing on the frame-start cycle survives to the next frame.
    pend_d   = (pend_q & ~frame_start) | bus.cfg_commit;
    sync_d   = (sync_q & ~frame_start) | bus.sync;

    if (bus.cfg_we) begin
      if (bus.cfg_sel) sh_off_d[bus.cfg_ch] = bus.cfg_data;
      else             sh_inc_d[bus.cfg_ch] = bus.cfg_data;
    end
    if (apply) begin
      inc_d = sh_inc_q;
      off_d = sh_off_q;
    end
    if (bus.en) begin
      slot_d = slot_q + 1'b1;   // NUM_CH is a power of two: natural wrap
      if (zero) acc_d = '0;
      acc_d[slot_q] = cur_acc + cur_inc;
      a_d = ADDR_WIDTH'(phase >> TW);
    end
  end

  // Stage 1: quadrant folding. Cos is the same lookup one quadrant ahead,
  // which flips the index mirroring and moves the sign boundary.
  always_comb begin
    idx       = a_q[IW-1:0];
    sin_addr  = a_q[ADDR_WIDTH-2] ? ~idx : idx;
    cos_addr  = a_q[ADDR_WIDTH-2] ? idx : ~idx;
    sin_m_d   = sin_m_q;
    cos_m_d   = cos_m_q;
    sin_neg_d = sin_neg_q;
    cos_neg_d = cos_neg_q;
    if (bus.en) begin
      sin_m_d   = ROM[sin_addr];
      cos_m_d   = ROM[cos_addr];
      sin_neg_d = a_q[ADDR_WIDTH-1];
      cos_neg_d = a_q[ADDR_WIDTH-1] ^ a_q[ADDR_WIDTH-2];
    end
  end

  // Stage 2: apply sign. Output registers only load real samples so they
  // stay at zero until the pipeline has filled after reset.
  always_comb begin
    sin_ext    = {1'b0, sin_m_q};
    cos_ext    = {1'b0, cos_m_q};
    sin_d      = sin_q;
    cos_d      = cos_q;
    vld_pipe_d = vld_pipe_q;
    ch_d       = ch_q;
    if (bus.en) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:0], 1'b1};
      ch_d       = {ch_q[STAGES-1:0], slot_q};
      if (vld_pipe_q[STAGES-1]) begin
        sin_d = sin_neg_q ? -sin_ext : sin_ext;
        cos_d = cos_neg_q ? -cos_ext : cos_ext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q     <= '0;
      acc_q      <= '0;
      inc_q      <= '0;
      off_q      <= '0;
      sh_inc_q   <= '0;
      sh_off_q   <= '0;
      pend_q     <= 1'b0;
      sync_q     <= 1'b0;
      vld_pipe_q <= '0;
      ch_q       <= '0;
      a_q        <= '0;
      sin_m_q    <= '0;
      cos_m_q    <= '0;
      sin_neg_q  <= 1'b0;
      cos_neg_q  <= 1'b0;
      sin_q      <= '0;
      cos_q      <= '0;
    end else begin
      slot_q     <= slot_d;
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      off_q      <= off_d;
      sh_inc_q   <= sh_inc_d;
      sh_off_q   <= sh_off_d;
      pend_q     <= pend_d;
      sync_q     <= sync_d;
      vld_pipe_q <= vld_pipe_d;
      ch_q       <= ch_d;
      a_q        <= a_d;
      sin_m_q    <= sin_m_d;
      cos_m_q    <= cos_m_d;
      sin_neg_q  <= sin_neg_d;
      cos_neg_q  <= cos_neg_d;
      sin_q      <= sin_d;
      cos_q      <= cos_d;
    end
  end

  assign bus.cfg_pending = pend_q;
  assign bus.out_valid   = bus.en & vld_pipe_q[STAGES];
  assign bus.out_ch      = ch_q[STAGES];
  assign bus.sin_o       = sin_q;
  assign bus.cos_o       = cos_q;
endmodule

// File: tb/tb_dsp_nco_mc.sv
// Testbench for dsp_nco_mc: directed test-plan steps followed by a random
// phase, every cycle compared against a frame-level reference model that
// computes sin/cos directly from the phase with real arithmetic.
module tb_dsp_nco_mc;
  localparam int  NUM_CH = 4, PHI_WIDTH = 16, ADDR_WIDTH = 12, DATA_WIDTH = 12;
  localparam int  CW  = $clog2(NUM_CH);
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = real'(2**(DATA_WIDTH-1) - 1);

  logic clk, rst;
  dsp_nco_mc_if #(.NUM_CH(NUM_CH), .PHI_WIDTH(PHI_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus();

  dsp_nco_mc #(.NUM_CH(NUM_CH), .PHI_WIDTH(PHI_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
               .DATA_WIDTH(DATA_WIDTH), .USE_DITHER(0), .FILE_QSIN("dsp_nco_rom_qsin.txt"))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int ch; int s; int c; } samp_t;
  int                   m_slot;
  logic [PHI_WIDTH-1:0] m_acc[NUM_CH], m_inc[NUM_CH], m_off[NUM_CH];
  logic [PHI_WIDTH-1:0] m_sinc[NUM_CH], m_soff[NUM_CH];
  bit                   m_pend, m_sync, m_vld;
  samp_t                m_q[$];
  samp_t                m_out;

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic samp_t mk(input int ch, input logic [PHI_WIDTH-1:0] p);
    samp_t r;
    int    a;
    real   ang;
    a    = int'(p) >> (PHI_WIDTH - ADDR_WIDTH);
    ang  = 2.0 * PI * (real'(a) + 0.5) / real'(2**ADDR_WIDTH);
    r.ch = ch;
    r.s  = rnd(AMP * $sin(ang));
    r.c  = rnd(AMP * $cos(ang));
    return r;
  endfunction

  task automatic model_reset();
    m_slot = 0; m_pend = 0; m_sync = 0; m_vld = 0;
    m_q.delete();
    m_out = '{0, 0, 0};
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = '0; m_inc[i] = '0; m_off[i] = '0; m_sinc[i] = '0; m_soff[i] = '0;
    end
  endtask

  task automatic model_edge();
    bit fs;
    logic [PHI_WIDTH-1:0] p;
    fs = bus.en && (m_slot == 0);
    if (bus.en) begin
      if (fs && m_pend) for (int i = 0; i < NUM_CH; i++) begin
        m_inc[i] = m_sinc[i]; m_off[i] = m_soff[i];
      end
      if (fs && m_sync) for (int i = 0; i < NUM_CH; i++) m_acc[i] = '0;
      p = m_acc[m_slot] + m_off[m_slot];
      m_q.push_back(mk(m_slot, p));
      m_acc[m_slot] = m_acc[m_slot] + m_inc[m_slot];
      if (m_q.size() == 3) begin m_out = m_q.pop_front(); m_vld = 1; end
      m_slot = (m_slot + 1) % NUM_CH;
    end
    if (fs) begin m_pend = 0; m_sync = 0; end
    if (bus.cfg_commit) m_pend = 1;
    if (bus.sync) m_sync = 1;
    if (bus.cfg_we) begin
      if (bus.cfg_sel) m_soff[bus.cfg_ch] = bus.cfg_data;
      else             m_sinc[bus.cfg_ch] = bus.cfg_data;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid",   bus.out_valid,   bus.en & m_vld);
    chk("out_ch",      bus.out_ch,      m_out.ch);
    chk("sin_o",       bus.sin_o,       m_out.s);
    chk("cos_o",       bus.cos_o,       m_out.c);
    chk("cfg_pending", bus.cfg_pending, m_pend);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input int ch, input bit sel, input int data);
    bus.cfg_we = 1'b1; bus.cfg_ch = CW'(ch); bus.cfg_sel = sel; bus.cfg_data = PHI_WIDTH'(data);
    cyc();
    bus.cfg_we = 1'b0;
  endtask

  task automatic to_slot(input int s);
    for (int i = 0; i < NUM_CH && m_slot != s; i++) cyc();
  endtask

  task automatic commit_wait();
    bus.cfg_commit = 1'b1;
    cyc();
    bus.cfg_commit = 1'b0;
    for (int i = 0; i < 3 * NUM_CH && m_pend; i++) cyc();
    chk("commit_applied", bus.cfg_pending, 0);
  endtask

  int got_s[8], got_c[8];
  task automatic collect(input int ch, input int n);
    int k = 0;
    for (int i = 0; i < n * NUM_CH * 2 + 8 && k < n; i++) begin
      cyc();
      if (bus.out_valid === 1'b1 && int'(bus.out_ch) == ch) begin
        got_s[k] = bus.sin_o; got_c[k] = bus.cos_o; k++;
      end
    end
    chk("collect_count", k, n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   bus.out_valid,   0);
    chk({tag, "_ch"},      bus.out_ch,      0);
    chk({tag, "_sin"},     bus.sin_o,       0);
    chk({tag, "_cos"},     bus.cos_o,       0);
    chk({tag, "_pending"}, bus.cfg_pending, 0);
  endtask

  initial begin
    int exp_s[5], exp_c[5];
    rst = 1'b0;
    bus.en = 1'b0; bus.sync = 1'b0; bus.cfg_we = 1'b0; bus.cfg_ch = '0;
    bus.cfg_sel = 1'b0; bus.cfg_data = '0; bus.cfg_commit = 1'b0;
    model_reset();

    // 1: reset state, fill latency, default outputs
    #1 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    idle(2);
    rst = 1'b0; bus.en = 1'b1;
    cyc(); chk("lat_c1_valid", bus.out_valid, 0);
    cyc(); chk("lat_c2_valid", bus.out_valid, 0);
    cyc(); chk("lat_c3_valid", bus.out_valid, 1);
    chk("lat_c3_ch", bus.out_ch, 0);
    chk("default_sin", bus.sin_o, 2);
    chk("default_cos", bus.cos_o, 2047);
    idle(8);

    // 2: ch0 steps a quarter turn per frame
    wr(0, 1'b0, 16384);
    commit_wait();
    collect(0, 5);
    exp_s = '{2, 2047, -2, -2047, 2};
    exp_c = '{2047, -2, -2047, 2, 2047};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("quarter_sin%0d", i), got_s[i], exp_s[i]);
      chk($sformatf("quarter_cos%0d", i), got_c[i], exp_c[i]);
    end

    // 3: half-turn offset on ch1; shadow write alone changes nothing
    wr(1, 1'b1, 32768);
    commit_wait();
    collect(1, 2);
    chk("half_sin", got_s[1], -2);
    chk("half_cos", got_c[1], -2047);
    wr(2, 1'b0, 1234);
    chk("nocommit_pending", bus.cfg_pending, 0);
    collect(2, 2);
    chk("nocommit_sin", got_s[1], 2);
    chk("nocommit_cos", got_c[1], 2047);

    // 4: commit mid-frame stays pending until the next slot 0
    to_slot(2);
    bus.cfg_commit = 1'b1; cyc(); bus.cfg_commit = 1'b0;
    chk("mid_commit_pend_a", bus.cfg_pending, 1);
    cyc(); chk("mid_commit_pend_b", bus.cfg_pending, 1);
    cyc(); chk("mid_commit_cleared", bus.cfg_pending, 0);
    idle(2 * NUM_CH);

    // 5: sync restarts ch0 from its offset
    wr(0, 1'b0, 4096);
    commit_wait();
    idle(3);
    bus.sync = 1'b1; cyc(); bus.sync = 1'b0;
    for (int i = 0; i < 2 * NUM_CH && m_sync; i++) cyc();
    collect(0, 4);
    chk("sync_sin0", got_s[0], 2);
    chk("sync_cos0", got_c[0], 2047);

    // 6: en gap mid-frame, then reset mid-frame drops pending commit/sync
    to_slot(2);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("gap_valid", bus.out_valid, 0);
    end
    bus.en = 1'b1;
    idle(2 * NUM_CH + 1);
    wr(3, 1'b1, 16384);
    bus.cfg_commit = 1'b1; bus.sync = 1'b1; cyc();
    bus.cfg_commit = 1'b0; bus.sync = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    model_reset();
    idle(2);
    rst = 1'b0;
    wr(3, 1'b1, 16384);
    idle(3 * NUM_CH);

    // 7: random traffic
    for (int i = 0; i < 300; i++) begin
      bus.en         = ($urandom_range(0, 7) != 0);
      bus.cfg_we     = ($urandom_range(0, 3) == 0);
      bus.cfg_ch     = CW'($urandom_range(0, NUM_CH - 1));
      bus.cfg_sel    = 1'($urandom_range(0, 1));
      bus.cfg_data   = PHI_WIDTH'($urandom);
      bus.cfg_commit = ($urandom_range(0, 15) == 0);
      bus.sync       = ($urandom_range(0, 31) == 0);
      cyc();
    end
    bus.cfg_we = 1'b0; bus.cfg_commit = 1'b0; bus.sync = 1'b0; bus.en = 1'b1;
    idle(2 * NUM_CH);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
